// File: rtl/matrix_result_unloader.sv
// Captures a 2x2 product frame on the rise of multiplication_done and streams it MSB-first as bytes.
// Valid one cycle after the rise; each beat holds until out_ready, so an idle sink stalls without loss.
module matrix_result_unloader #(
  parameter int RESULT_W = 16,
  parameter int NUM_RES  = 4,
  parameter int OUT_W    = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [RESULT_W-1:0] i_result1,
  input  logic [RESULT_W-1:0] i_result2,
  input  logic [RESULT_W-1:0] i_result3,
  input  logic [RESULT_W-1:0] i_result4,
  input  logic                i_multiplication_done,
  output logic [OUT_W-1:0]    o_out_data,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic                o_out_last,
  output logic                o_busy,
  output logic                o_overrun
);

  localparam int BEATS   = NUM_RES * (RESULT_W / OUT_W);
  localparam int FRAME_W = NUM_RES * RESULT_W;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAST    = BEATS - 1;

  typedef logic [FRAME_W-1:0] frame_t;
  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t             r_state;
  logic               r_done_q;
  frame_t             r_frame;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_overrun;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_capture;
  logic               w_overrun_nxt;
  logic               w_rise;
  logic               w_hs;
  logic               w_at_last;
  logic [OUT_W-1:0]   w_byte;
  frame_t             w_frame_in;

  // result1 occupies the top bits so beat 0 is its most significant byte
  assign w_frame_in = {i_result1, i_result2, i_result3, i_result4};
  assign w_rise     = i_multiplication_done & ~r_done_q;
  assign w_hs       = (r_state == S_STREAM) & i_out_ready;
  assign w_at_last  = (r_cnt == CNT_W'(LAST));

  always_comb begin
    w_byte = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (r_cnt == CNT_W'(b)) begin
        w_byte = r_frame[FRAME_W-1-b*OUT_W -: OUT_W];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_capture     = 1'b0;
    w_overrun_nxt = r_overrun;
    o_out_valid   = 1'b0;
    o_busy        = 1'b0;
    o_out_last    = 1'b0;
    o_out_data    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        o_out_valid = 1'b1;
        o_busy      = 1'b1;
        o_out_last  = w_at_last;
        o_out_data  = w_byte;
        if (w_hs && w_at_last) begin
          // A rise landing on the closing handshake chains straight into the next frame
          w_cnt_nxt = '0;
          if (w_rise) begin
            w_capture = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          if (w_hs) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
          if (w_rise) begin
            w_overrun_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_done_q  <= 1'b0;
      r_frame   <= '0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done_q  <= i_multiplication_done;
      r_cnt     <= w_cnt_nxt;
      r_overrun <= w_overrun_nxt;
      if (w_capture) begin
        r_frame <= w_frame_in;
      end
    end
  end

  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_matrix_result_unloader.sv
// Directed bench for matrix_result_unloader: hand-computed byte frames, edge cases of done/ready/rst.
module tb_matrix_result_unloader;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] r1, r2, r3, r4;
  logic        done;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  matrix_result_unloader dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_result1             (r1),
    .i_result2             (r2),
    .i_result3             (r3),
    .i_result4             (r4),
    .i_multiplication_done (done),
    .o_out_data            (out_data),
    .o_out_valid           (out_valid),
    .i_out_ready           (out_ready),
    .o_out_last            (out_last),
    .o_busy                (busy),
    .o_overrun             (overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_last"},  32'(out_last),  32'd0);
    check({tag, "_data"},  32'(out_data),  32'd0);
  endtask

  // Consumes eight beats with out_ready high; exp lists the bytes beat 0 first
  task automatic run_frame(input string tag, input logic [63:0] exp);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_valid%0d", tag, k), 32'(out_valid), 32'd1);
      check($sformatf("%s_data%0d", tag, k),  32'(out_data),  32'(exp[63-8*k -: 8]));
      check($sformatf("%s_last%0d", tag, k),  32'(out_last),  32'(k == 7));
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int nb, nl, nv;
    rst = 1'b1; done = 1'b0; out_ready = 1'b1;
    r1 = '0; r2 = '0; r3 = '0; r4 = '0;
    do_reset();
    check_idle("reset");
    check("reset_overrun", 32'(overrun), 32'd0);

    // T1: back-to-back beats, valid one cycle after the rise
    r1 = 16'h0001; r2 = 16'h0002; r3 = 16'h0003; r4 = 16'h0004;
    done = 1'b1;
    check("t1_pre_valid", 32'(out_valid), 32'd0);
    step();
    done = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    run_frame("t1", 64'h00_01_00_02_00_03_00_04);
    check_idle("t1_end");

    // T2: ready toggling; inputs change after capture and must not leak in
    r1 = 16'h0013; r2 = 16'h0023; r3 = 16'h0024; r4 = 16'h0034;
    done = 1'b1;
    step();
    done = 1'b0;
    r1 = 16'hdead; r2 = 16'hbeef; r3 = 16'hdead; r4 = 16'hbeef;
    for (int k = 0; k < 8; k++) begin
      logic [63:0] exp2;
      exp2 = 64'h00_13_00_23_00_24_00_34;
      out_ready = 1'b0;
      check($sformatf("t2_hold%0d", k), 32'(out_data), 32'(exp2[63-8*k -: 8]));
      step();
      out_ready = 1'b1;
      check($sformatf("t2_data%0d", k), 32'(out_data), 32'(exp2[63-8*k -: 8]));
      check($sformatf("t2_last%0d", k), 32'(out_last), 32'(k == 7));
      step();
    end
    check_idle("t2_end");

    // T3: done held high for 20 cycles yields one frame only
    r1 = 16'h1111; r2 = 16'h2222; r3 = 16'h3333; r4 = 16'h4444;
    done = 1'b1;
    nb = 0; nl = 0;
    step();
    for (int i = 0; i < 24; i++) begin
      if (i == 19) done = 1'b0;
      if (out_valid) nb++;
      if (out_last) nl++;
      step();
    end
    check("t3_beats", 32'(nb), 32'd8);
    check("t3_lasts", 32'(nl), 32'd1);
    check("t3_overrun", 32'(overrun), 32'd0);

    // T4: second rise at beat 3 is dropped and flagged
    r1 = 16'h1234; r2 = 16'h5678; r3 = 16'h9abc; r4 = 16'hdef0;
    done = 1'b1;
    step();
    done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic [63:0] exp4;
      exp4 = 64'h12_34_56_78_9a_bc_de_f0;
      check($sformatf("t4_data%0d", k), 32'(out_data), 32'(exp4[63-8*k -: 8]));
      check($sformatf("t4_valid%0d", k), 32'(out_valid), 32'd1);
      if (k == 3) begin
        done = 1'b1;
        r1 = 16'hffff; r2 = 16'hffff; r3 = 16'hffff; r4 = 16'hffff;
      end
      step();
      done = 1'b0;
    end
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) nv++;
      step();
    end
    check("t4_no_second_frame", 32'(nv), 32'd0);
    check("t4_overrun", 32'(overrun), 32'd1);

    // T5: rise coincident with the beat-7 handshake chains frames without a gap
    do_reset();
    check("t5_overrun_cleared", 32'(overrun), 32'd0);
    r1 = 16'h0102; r2 = 16'h0304; r3 = 16'h0506; r4 = 16'h0708;
    done = 1'b1;
    step();
    done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic [63:0] exp5;
      exp5 = 64'h01_02_03_04_05_06_07_08;
      check($sformatf("t5a_data%0d", k), 32'(out_data), 32'(exp5[63-8*k -: 8]));
      if (k == 7) begin
        done = 1'b1;
        r1 = 16'ha1a2; r2 = 16'ha3a4; r3 = 16'ha5a6; r4 = 16'ha7a8;
      end
      step();
    end
    done = 1'b0;
    run_frame("t5b", 64'ha1_a2_a3_a4_a5_a6_a7_a8);
    check_idle("t5_end");
    check("t5_overrun", 32'(overrun), 32'd0);

    // T6: reset mid-frame discards everything, including overrun
    r1 = 16'h1111; r2 = 16'h2222; r3 = 16'h3333; r4 = 16'h4444;
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    check("t6_overrun_set", 32'(overrun), 32'd1);
    step();
    step();
    check("t6_beat4", 32'(out_data), 32'h33);
    rst = 1'b1;
    step();
    check_idle("t6_rst");
    check("t6_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid) nv++;
    end
    check("t6_no_resume", 32'(nv), 32'd0);

    // Stall: ready low for a long time holds beat 0, then the frame drains intact
    r1 = 16'hcafe; r2 = 16'hbeef; r3 = 16'h0bad; r4 = 16'hf00d;
    out_ready = 1'b0;
    done = 1'b1;
    step();
    done = 1'b0;
    repeat (30) step();
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_data", 32'(out_data), 32'hca);
    out_ready = 1'b1;
    run_frame("stall", 64'hca_fe_be_ef_0b_ad_f0_0d);
    check_idle("stall_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
